approx_mult_error_engine: RTL



---
 rtl/approx_mult_error_engine_pkg.sv | 21 ++
 rtl/approx_mult_error_engine_divider.sv | 63 ++++++
 rtl/approx_mult_error_engine.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/approx_mult_error_engine_pkg.sv
// Shared constants for the approximate-multiplier error engine.
// Holds default operand/fraction widths, derived product/quotient widths,
// the number of operand pairs, and the sweep FSM state encoding.
package approx_mult_error_engine_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int FRAC_DEF  = 8;
  localparam int PW_DEF    = 2 * WIDTH_DEF;
  localparam int QW_DEF    = PW_DEF + FRAC_DEF;
  localparam int N_DEF     = 1 << (2 * WIDTH_DEF);

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_APPLY   = 3'd1;
  localparam state_t S_CAPTURE = 3'd2;
  localparam state_t S_DIV     = 3'd3;
  localparam state_t S_ACCUM   = 3'd4;
  localparam state_t S_DONE    = 3'd5;

endpackage

// File: rtl/approx_mult_error_engine_divider.sv
// seq_restoring_divider: unsigned restoring divider, one quotient bit per cycle.
// Ports: clk/rst, start loads dividend[QW] and divisor[PW]; quotient[QW] is
// valid (and valid pulses) QW cycles after start. Divisor must be non-zero.
module seq_restoring_divider #(
  parameter int QW = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [QW-1:0] dividend,
  input  logic [PW-1:0] divisor,
  output logic [QW-1:0] quotient,
  output logic          valid
);

  localparam int CW = $clog2(QW + 1);

  logic [PW-1:0] r_rem;
  logic [PW-1:0] r_dvs;
  // Dividend bits shift out the top while quotient bits shift in at the bottom,
  // so after QW steps this register holds the quotient.
  logic [QW-1:0] r_dvd;
  logic [CW-1:0] r_cnt;
  logic          r_valid;

  logic [PW:0]   w_trial;
  logic          w_ge;
  logic [PW-1:0] w_diff;

  assign w_trial = {r_rem, r_dvd[QW-1]};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});
  // When w_ge holds the true difference is below the divisor, so the low PW
  // bits of a modular subtraction are exact.
  assign w_diff  = w_trial[PW-1:0] - r_dvs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= '0;
      r_dvs   <= '0;
      r_dvd   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (start) begin
        r_rem <= '0;
        r_dvs <= divisor;
        r_dvd <= dividend;
        r_cnt <= CW'(QW);
      end else if (r_cnt != '0) begin
        r_rem <= w_ge ? w_diff : w_trial[PW-1:0];
        r_dvd <= {r_dvd[QW-2:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) r_valid <= 1'b1;
      end
    end
  end

  assign quotient = r_dvd;
  assign valid    = r_valid;

endmodule

// File: rtl/approx_mult_error_engine.sv
// approx_mult_error_engine: sweeps every operand pair through an external
// approximate multiplier, compares against the exact product and accumulates
// abs-error sum, error count, max error and fixed-point relative-error sum.
// Ports: clk/rst, start -> busy/done; op_a/op_b out, approx_result in; results out.
module approx_mult_error_engine
  import approx_mult_error_engine_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int FRAC   = FRAC_DEF,
  parameter  int SETTLE = 1,
  localparam int PW     = 2 * WIDTH,
  localparam int QW     = PW + FRAC,
  localparam int IW     = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [PW-1:0]    approx_result,
  output logic [2*PW-1:0]  sum_abs_err,
  output logic [IW:0]      err_count,
  output logic [PW-1:0]    max_err,
  output logic [QW+IW-1:0] sum_rel_err,
  output logic [QW-1:0]    mean_rel_err
);

  localparam int SAW = 2 * PW;
  localparam int CNW = IW + 1;
  localparam int SRW = QW + IW;
  localparam int CW  = $clog2(QW + 16);

  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(QW - 1);
  localparam logic [IW-1:0] IDX_LAST = '1;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_exact;
  logic [PW-1:0]   r_d;
  logic [SAW-1:0]  r_sum_abs;
  logic [CNW-1:0]  r_err_cnt;
  logic [PW-1:0]   r_max;
  logic [SRW-1:0]  r_sum_rel;

  logic [PW-1:0]   w_a_ext;
  logic [PW-1:0]   w_b_ext;
  logic [PW-1:0]   w_exact;
  logic [PW-1:0]   w_d;
  logic            w_div_start;
  logic [QW-1:0]   w_dividend;
  logic [QW-1:0]   w_quot;
  logic            w_div_valid;
  logic [QW-1:0]   w_rel;

  assign op_a    = r_idx[IW-1:WIDTH];
  assign op_b    = r_idx[WIDTH-1:0];
  assign w_a_ext = {{WIDTH{1'b0}}, op_a};
  assign w_b_ext = {{WIDTH{1'b0}}, op_b};
  assign w_exact = w_a_ext * w_b_ext;
  assign w_d     = (approx_result >= w_exact) ? (approx_result - w_exact)
                                              : (w_exact - approx_result);

  // The divider is launched straight from CAPTURE with the live values, so it
  // never sees a zero divisor.
  assign w_div_start = (r_state == S_CAPTURE) && (w_exact != '0);
  assign w_dividend  = {w_d, {FRAC{1'b0}}};

  seq_restoring_divider #(
    .QW (QW),
    .PW (PW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_div_start),
    .dividend (w_dividend),
    .divisor  (w_exact),
    .quotient (w_quot),
    .valid    (w_div_valid)
  );

  // Relative error contributes nothing for pairs whose exact product is zero.
  assign w_rel = ((r_exact == '0) || !w_div_valid) ? '0 : w_quot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_exact   <= '0;
      r_d       <= '0;
      r_sum_abs <= '0;
      r_err_cnt <= '0;
      r_max     <= '0;
      r_sum_rel <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx     <= '0;
            r_cnt     <= '0;
            r_exact   <= '0;
            r_d       <= '0;
            r_sum_abs <= '0;
            r_err_cnt <= '0;
            r_max     <= '0;
            r_sum_rel <= '0;
            r_state   <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (r_cnt == SET_LAST) begin
            r_cnt   <= '0;
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          r_exact <= w_exact;
          r_d     <= w_d;
          r_cnt   <= '0;
          r_state <= (w_exact == '0) ? S_ACCUM : S_DIV;
        end
        S_DIV: begin
          // Leaves on the same edge the divider retires its last bit.
          if (r_cnt == DIV_LAST) begin
            r_cnt   <= '0;
            r_state <= S_ACCUM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          r_sum_abs <= r_sum_abs + SAW'(r_d);
          r_err_cnt <= r_err_cnt + CNW'(r_d != '0);
          if (r_d > r_max) r_max <= r_d;
          r_sum_rel <= r_sum_rel + SRW'(w_rel);
          if (r_idx == IDX_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_APPLY;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (r_state == S_APPLY) || (r_state == S_CAPTURE) ||
                        (r_state == S_DIV)   || (r_state == S_ACCUM);
  assign done         = (r_state == S_DONE);
  assign sum_abs_err  = r_sum_abs;
  assign err_count    = r_err_cnt;
  assign max_err      = r_max;
  assign sum_rel_err  = r_sum_rel;
  // Mean over all N pairs, zero-product pairs included; plain truncation.
  assign mean_rel_err = r_sum_rel[SRW-1:IW];

endmodule
